gol_sched: RTL and testbench

Generation scheduler for the Game of Life core: it decides when the next-field iteration engine runs and when the field config loader may take the field. It handles run/pause and single-step commands and paces generations with a tick counter. It grants the loader's `FCL_allowed` input only when no iteration is in flight, and counts generations for the display. It sits between the user command inputs, `FCL_controller` and the next-field iteration engine.

---
 rtl/gol_sched.sv | 173 +++++++++++++++++
 tb/tb_gol_sched.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gol_sched.sv
// gol_sched: generation scheduler for the Game of Life core.
// Paces the next-field iteration engine with a tick counter and handles
// run/pause and single-step commands. It lends the field to the config
// loader only while no iteration is in flight, and counts completed
// generations for the display.
// Optional feature: define GOL_SCHED_SPEED_SEL_EN to add the i_speed port,
// which shortens the generation period to TICK_PERIOD >> i_speed (minimum 2).
module gol_sched #(
    parameter int TICK_PERIOD = 25_000_000,
    parameter int GEN_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_cmd_run,
    input  logic                 i_cmd_step,
`ifdef GOL_SCHED_SPEED_SEL_EN
    input  logic [1:0]           i_speed,
`endif
    input  logic                 i_is_loading,
    input  logic                 i_iter_done,
    output logic                 o_FCL_allowed,
    output logic                 o_iter_go,
    output logic                 o_running,
    output logic [GEN_CNT_W-1:0] o_gen_cnt
);

    localparam int TICK_W = (TICK_PERIOD > 2) ? $clog2(TICK_PERIOD) : 1;

    typedef enum logic [1:0] {
        ST_PAUSED,
        ST_WAIT,
        ST_ITER,
        ST_LOAD
    } state_t;

    state_t              state;
    state_t              next_state;
    logic                run;
    logic                run_next;
    logic                prev_run;
    logic                prev_step;
    logic                run_ev;
    logic                step_ev;
    logic                gen_inc;
    logic                gen_clr;
    logic                wait_entry;
    logic [TICK_W-1:0]   tick;
    logic [TICK_W-1:0]   tick_last;

    // A simultaneous run edge suppresses the step edge.
    assign run_ev  = i_cmd_run & ~prev_run;
    assign step_ev = i_cmd_step & ~prev_step & ~run_ev;

`ifdef GOL_SCHED_SPEED_SEL_EN
    // Last tick value for the selected speed, clamped to a period of 2.
    function automatic logic [TICK_W-1:0] period_last(input logic [1:0] speed);
        int eff;
        eff = TICK_PERIOD >> speed;
        if (eff < 2) begin
            eff = 2;
        end
        return TICK_W'(eff - 1);
    endfunction

    // Period is captured when WAIT is entered so mid-WAIT speed changes wait for the next entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_last <= TICK_W'(TICK_PERIOD - 1);
        end else if (wait_entry) begin
            tick_last <= period_last(i_speed);
        end
    end
`else
    assign tick_last = TICK_W'(TICK_PERIOD - 1);
`endif

    // Next-state, run flag and generation counter control.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        next_state = state;
        run_next   = run;
        gen_inc    = 1'b0;
        gen_clr    = 1'b0;
        case (state)
            ST_PAUSED: begin
                if (i_is_loading) begin
                    next_state = ST_LOAD;
                end else if (run_ev) begin
                    run_next   = 1'b1;
                    next_state = ST_WAIT;
                end else if (step_ev) begin
                    next_state = ST_ITER;
                end
            end
            ST_WAIT: begin
                if (i_is_loading) begin
                    run_next   = 1'b0;
                    next_state = ST_LOAD;
                end else if (run_ev) begin
                    run_next   = 1'b0;
                    next_state = ST_PAUSED;
                end else if (tick == tick_last) begin
                    next_state = ST_ITER;
                end
            end
            ST_ITER: begin
                // The loader is locked out here, so i_is_loading is not looked at.
                if (run_ev) begin
                    run_next = ~run;
                end
                if (i_iter_done) begin
                    gen_inc    = 1'b1;
                    next_state = run_next ? ST_WAIT : ST_PAUSED;
                end
            end
            ST_LOAD: begin
                if (!i_is_loading) begin
                    gen_clr    = 1'b1;
                    next_state = ST_PAUSED;
                end
            end
            default: begin
                next_state = ST_PAUSED;
            end
        endcase
    end

    assign wait_entry = (next_state == ST_WAIT) && (state != ST_WAIT);

    // State, run flag, command edge history and start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_PAUSED;
            run       <= 1'b0;
            prev_run  <= 1'b0;
            prev_step <= 1'b0;
            o_iter_go <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= next_state;
            run       <= run_next;
            prev_run  <= i_cmd_run;
            prev_step <= i_cmd_step;
            o_iter_go <= (next_state == ST_ITER) && (state != ST_ITER);
        end
    end

    // Tick counter: cleared on WAIT entry, counts every cycle spent in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick <= '0;
        end else if (wait_entry) begin
            tick <= '0;
        end else if (state == ST_WAIT) begin
            tick <= tick + 1'b1;
        end
    end

    // Generation counter: wraps naturally, cleared when a load finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_gen_cnt <= '0;
        end else if (gen_clr) begin
            o_gen_cnt <= '0;
        end else if (gen_inc) begin
            o_gen_cnt <= o_gen_cnt + 1'b1;
        end
    end

    assign o_running     = run;
    assign o_FCL_allowed = (state == ST_PAUSED) || (state == ST_WAIT);

endmodule

// File: tb/tb_gol_sched.sv
// Self-checking bench for gol_sched: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against
// a behavioural model of the scheduler.
module tb_gol_sched;

    localparam int TP  = 8;
    localparam int GW  = 2;

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b0;
    logic          i_cmd_run    = 1'b0;
    logic          i_cmd_step   = 1'b0;
    logic          i_is_loading = 1'b0;
    logic          i_iter_done  = 1'b0;
`ifdef GOL_SCHED_SPEED_SEL_EN
    logic [1:0]    i_speed      = 2'd0;
`endif
    logic          o_FCL_allowed;
    logic          o_iter_go;
    logic          o_running;
    logic [GW-1:0] o_gen_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int lat      = 3;
    int eng_cnt  = 0;

    gol_sched #(.TICK_PERIOD(TP), .GEN_CNT_W(GW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cmd_run    (i_cmd_run),
        .i_cmd_step   (i_cmd_step),
`ifdef GOL_SCHED_SPEED_SEL_EN
        .i_speed      (i_speed),
`endif
        .i_is_loading (i_is_loading),
        .i_iter_done  (i_iter_done),
        .o_FCL_allowed(o_FCL_allowed),
        .o_iter_go    (o_iter_go),
        .o_running    (o_running),
        .o_gen_cnt    (o_gen_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    bit m_load, m_iter, m_run, m_go, m_prev_run, m_prev_step;
    int m_left, m_gen;

    function automatic int period_now();
`ifdef GOL_SCHED_SPEED_SEL_EN
        int p;
        p = TP >> i_speed;
        if (p < 2) p = 2;
        return p;
`else
        return TP;
`endif
    endfunction

    task automatic m_reset();
        m_load = 0; m_iter = 0; m_run = 0; m_go = 0;
        m_prev_run = 0; m_prev_step = 0; m_left = 0; m_gen = 0;
    endtask

    task automatic m_advance();
        bit rev, sev;
        rev = i_cmd_run && !m_prev_run;
        sev = i_cmd_step && !m_prev_step && !rev;
        m_prev_run  = i_cmd_run;
        m_prev_step = i_cmd_step;
        m_go = 0;
        if (m_load) begin
            if (!i_is_loading) begin
                m_load = 0;
                m_gen  = 0;
            end
        end else if (m_iter) begin
            if (rev) m_run = !m_run;
            if (i_iter_done) begin
                m_gen  = (m_gen + 1) % (1 << GW);
                m_iter = 0;
                if (m_run) m_left = period_now();
            end
        end else if (m_run) begin
            if (i_is_loading) begin
                m_run = 0; m_load = 1;
            end else if (rev) begin
                m_run = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_iter = 1; m_go = 1;
                end
            end
        end else begin
            if (i_is_loading) m_load = 1;
            else if (rev) begin
                m_run = 1; m_left = period_now();
            end else if (sev) begin
                m_iter = 1; m_go = 1;
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_advance();
        end
    end

    // Compare DUT against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("mdl_allowed", o_FCL_allowed, !m_load && !m_iter);
            check("mdl_go", o_iter_go, m_go);
            check("mdl_running", o_running, m_run);
            check("mdl_gen", o_gen_cnt, m_gen);
        end
    end

    // Iteration engine stand-in: done pulse lat+1 cycles after each go.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                eng_cnt = 0;
                i_iter_done = 1'b0;
            end else begin
                #1;
                i_iter_done = 1'b0;
                if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt == 0) i_iter_done = 1'b1;
                end else if (o_iter_go) begin
                    eng_cnt = lat + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_go(input string name, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_iter_go && n < budget);
        check({name, "_seen"}, o_iter_go, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, gos, load_left;
        int exp_wrap [5] = '{1, 2, 3, 0, 1};

        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("idle_allowed", o_FCL_allowed, 1);
        check("idle_go", o_iter_go, 0);
        check("idle_running", o_running, 0);
        check("idle_gen", o_gen_cnt, 0);

        // Step held for 4 cycles: one pulse, done 5 cycles after go.
        lat = 4;
        i_cmd_step = 1'b1;
        tick();
        check("step_go", o_iter_go, 1);
        check("step_allowed", o_FCL_allowed, 0);
        gos = 0;
        repeat (3) begin tick(); gos += int'(o_iter_go); end
        i_cmd_step = 1'b0;
        check("step_single_pulse", gos, 0);
        tick(); tick();
        check("step_busy", o_FCL_allowed, 0);
        tick();
        check("step_gen", o_gen_cnt, 1);
        check("step_back_paused", o_FCL_allowed, 1);

        // Running cadence.
        lat = 3;
        tick();
        i_cmd_run = 1'b1;
        wait_go("run_first", 40, n);
        check("run_first_delay", n, TP + 1);
        wait_go("cadence1", 40, n);
        check("cadence1_len", n, TP + 1 + lat + 1);
        wait_go("cadence2", 40, n);
        check("cadence2_len", n, TP + 1 + lat + 1);
        i_cmd_run = 1'b0;
        tick();
        i_cmd_run = 1'b1;
        tick();
        check("pause_running", o_running, 0);
        gos = 0;
        repeat (30) begin tick(); gos += int'(o_iter_go); end
        check("pause_no_go", gos, 0);
        check("pause_allowed", o_FCL_allowed, 1);

        // Run and step edges together: run wins.
        i_cmd_run = 1'b0;
        tick();
        i_cmd_run = 1'b1;
        i_cmd_step = 1'b1;
        tick();
        check("runstep_running", o_running, 1);
        check("runstep_no_go", o_iter_go, 0);
        wait_go("runstep", 40, n);
        check("runstep_first_go", n, TP);
        i_cmd_run = 1'b0;
        i_cmd_step = 1'b0;

        // Load while running (now in WAIT after the iteration returns).
        repeat (6) tick();
        check("preload_gen", o_gen_cnt, 1);
        i_is_loading = 1'b1;
        tick();
        check("load_allowed", o_FCL_allowed, 0);
        check("load_running", o_running, 0);
        repeat (4) tick();
        i_is_loading = 1'b0;
        tick();
        check("unload_gen", o_gen_cnt, 0);
        check("unload_allowed", o_FCL_allowed, 1);
        check("unload_running", o_running, 0);

        // Load request during ITER is ignored.
        lat = 4;
        tick();
        i_cmd_step = 1'b1;
        tick();
        i_cmd_step = 1'b0;
        i_is_loading = 1'b1;
        tick(); tick();
        i_is_loading = 1'b0;
        check("iterload_allowed", o_FCL_allowed, 0);
        repeat (4) tick();
        check("iterload_gen", o_gen_cnt, 1);
        check("iterload_allowed_after", o_FCL_allowed, 1);

        // Clear via a load, then five steps to exercise the wrap.
        i_is_loading = 1'b1;
        tick(); tick();
        i_is_loading = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            i_cmd_step = 1'b1;
            tick();
            i_cmd_step = 1'b0;
            repeat (6) tick();
            check($sformatf("wrap_%0d", i), o_gen_cnt, exp_wrap[i]);
        end

`ifdef GOL_SCHED_SPEED_SEL_EN
        // Speed select 2 with TICK_PERIOD 8 gives an effective period of 2.
        lat = 3;
        i_speed = 2'd2;
        i_cmd_run = 1'b0;
        tick();
        i_cmd_run = 1'b1;
        wait_go("speed_first", 40, n);
        check("speed_first_delay", n, 3);
        wait_go("speed_cad", 40, n);
        check("speed_cad_len", n, 2 + 1 + lat + 1);
        i_cmd_run = 1'b0;
        tick();
        i_cmd_run = 1'b1;
        repeat (12) tick();
        i_cmd_run = 1'b0;
        i_speed = 2'd0;
`endif

        // Asynchronous reset in the middle of an iteration.
        lat = 4;
        tick();
        i_cmd_step = 1'b1;
        tick();
        i_cmd_step = 1'b0;
        tick();
        #3 rst_n = 1'b0;
        #1;
        check("arst_allowed", o_FCL_allowed, 1);
        check("arst_go", o_iter_go, 0);
        check("arst_gen", o_gen_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized phase.
        load_left = 0;
        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(0, 4);
            if ($urandom_range(0, 15) == 0) i_cmd_run = ~i_cmd_run;
            if ($urandom_range(0, 7) == 0) i_cmd_step = ~i_cmd_step;
`ifdef GOL_SCHED_SPEED_SEL_EN
            if ($urandom_range(0, 63) == 0) i_speed = 2'($urandom_range(0, 3));
`endif
            if (load_left > 0) begin
                load_left--;
                i_is_loading = (load_left > 0);
            end else if ($urandom_range(0, 99) == 0) begin
                load_left = $urandom_range(1, 8);
                i_is_loading = 1'b1;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
